// File: rtl/b10_serializer.sv
// Parallel-to-serial stage for 10-bit 8b/10b symbols: a one-symbol holding register
// feeds a shift register clocked at the bit rate, with comma fill on underrun.
module b10_serializer #(
    parameter bit         LSB_FIRST = 1'b1,
    parameter logic [9:0] IDLE_SYM  = 10'h0FA,
    parameter int         UNDER_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en_n,
    input  logic [9:0]         sym_in,
    input  logic               sym_valid,
    output logic               sym_ready,
    output logic               txbit,
    output logic               sym_start,
    output logic [UNDER_W-1:0] underrun_cnt
);
    localparam logic [3:0] LAST_BIT = 4'd9;

    logic [9:0]         sr_q, sr_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [9:0]         hr_q, hr_d;
    logic               hr_full_q, hr_full_d;
    logic               armed_q, armed_d;
    logic [UNDER_W-1:0] under_q, under_d;

    logic       load;
    logic       accept;
    logic [9:0] sr_shift;
    logic [9:0] sym_clean;

    assign load      = (bit_cnt_q == LAST_BIT);
    assign sym_ready = !reset && !en_n && !hr_full_q;
    assign accept    = sym_valid && sym_ready;
    assign sr_shift  = LSB_FIRST ? {1'b0, sr_q[9:1]} : {sr_q[8:0], 1'b0};

    // A symbol carrying unknown bits is never put on the line; the comma goes instead.
    always_comb begin
        sym_clean = sym_in;
        if ($isunknown(sym_in)) sym_clean = IDLE_SYM;
    end

    always_comb begin
        // NOTE: every next-state variable takes its held value first, so no path
        // through this block leaves one unassigned and no latch is inferred.
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        hr_d      = hr_q;
        hr_full_d = hr_full_q;
        armed_d   = armed_q;
        under_d   = under_q;

        if (en_n) begin
            sr_d      = '0;
            bit_cnt_d = LAST_BIT;
            hr_full_d = 1'b0;
            armed_d   = 1'b0;
        end else begin
            if (accept) armed_d = 1'b1;
            if (load) begin
                bit_cnt_d = '0;
                if (hr_full_q) begin
                    sr_d      = hr_q;
                    hr_full_d = accept;
                    if (accept) hr_d = sym_clean;
                end else if (accept) begin
                    sr_d = sym_clean;
                end else begin
                    // Encoder ran dry: fill with comma; only count once traffic has started.
                    sr_d = IDLE_SYM;
                    if (armed_q && (under_q != '1)) under_d = under_q + UNDER_W'(1);
                end
            end else begin
                sr_d      = sr_shift;
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (accept) begin
                    hr_d      = sym_clean;
                    hr_full_d = 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values computed above, independent of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q      <= '0;
            bit_cnt_q <= LAST_BIT;
            hr_full_q <= 1'b0;
            armed_q   <= 1'b0;
            under_q   <= '0;
        end else begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            hr_full_q <= hr_full_d;
            armed_q   <= armed_d;
            under_q   <= under_d;
        end
    end

    // NOTE: the holding-register payload has no reset; hr_full_q qualifies it,
    // so stale contents are never observed.
    always_ff @(posedge clk) begin
        hr_q <= hr_d;
    end

    assign txbit        = LSB_FIRST ? sr_q[0] : sr_q[9];
    assign sym_start    = (bit_cnt_q == 4'd0);
    assign underrun_cnt = under_q;

endmodule

// File: tb/tb_b10_serializer.sv
// Scoreboard bench for b10_serializer: accepted symbols are queued and matched
// against frames reassembled from txbit; idle frames and underruns checked per scenario.
module tb_b10_serializer;
    localparam logic [9:0] IDLE = 10'h0FA;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, en_n, sym_valid;
    logic [9:0] sym_in;
    logic       sym_ready, txbit, sym_start;
    logic [7:0] underrun_cnt;

    logic       reset_m, en_n_m, sym_valid_m;
    logic [9:0] sym_in_m;
    logic       sym_ready_m, txbit_m, sym_start_m;
    logic [7:0] underrun_cnt_m;

    b10_serializer dut (
        .clk(clk), .reset(reset), .en_n(en_n), .sym_in(sym_in), .sym_valid(sym_valid),
        .sym_ready(sym_ready), .txbit(txbit), .sym_start(sym_start),
        .underrun_cnt(underrun_cnt)
    );

    b10_serializer #(.LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .reset(reset_m), .en_n(en_n_m), .sym_in(sym_in_m), .sym_valid(sym_valid_m),
        .sym_ready(sym_ready_m), .txbit(txbit_m), .sym_start(sym_start_m),
        .underrun_cnt(underrun_cnt_m)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [9:0] exp_q[$];
    int         idle_seen = 0;
    int         data_seen = 0;
    logic [9:0] frame;
    logic [9:0] want;
    int         nbits = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: push on accept, reassemble LSB-first frames, pop on data frames.
    always @(negedge clk) begin
        if (!reset && !en_n && sym_valid && sym_ready) exp_q.push_back(sym_in);
        if (reset || en_n) begin
            nbits = 0;
        end else if (sym_start || (nbits > 0)) begin
            if (sym_start) nbits = 0;
            frame[nbits] = txbit;
            nbits++;
            if (nbits == 10) begin
                nbits = 0;
                if (frame == IDLE) begin
                    idle_seen++;
                end else begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL frame_unexpected: got %h, required no data frame", frame);
                    end else begin
                        want = exp_q.pop_front();
                        data_seen++;
                        if (frame !== want) begin
                            bad++;
                            $display("FAIL frame_data: got %h, required %h", frame, want);
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; en_n = 1'b1; sym_valid = 1'b1; sym_in = 10'h2AA;
        reset_m = 1'b1; en_n_m = 1'b1; sym_valid_m = 1'b0; sym_in_m = 10'h000;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            total++;
            if ({txbit, sym_ready, sym_start, underrun_cnt} !== 11'd0) begin
                bad++;
                $display("FAIL reset_outputs k=%0d: got tx=%b rdy=%b start=%b cnt=%0d, required 0 0 0 0",
                         k, txbit, sym_ready, sym_start, underrun_cnt);
            end
        end
        step();
        reset = 1'b0;
        sym_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if ({txbit, sym_ready, sym_start, underrun_cnt} !== 11'd0) begin
                bad++;
                $display("FAIL off_outputs k=%0d: got tx=%b rdy=%b start=%b cnt=%0d, required 0 0 0 0",
                         k, txbit, sym_ready, sym_start, underrun_cnt);
            end
        end
    endtask

    task automatic test_idle();
        int         i0;
        logic [9:0] idle_v;
        logic       want_bit, want_start;
        idle_v = IDLE;
        step();
        en_n = 1'b0;
        i0 = idle_seen;
        @(negedge clk);
        total++;
        if (sym_ready !== 1'b1 || sym_start !== 1'b0) begin
            bad++;
            $display("FAIL idle_preload: got rdy=%b start=%b, required 1 0", sym_ready, sym_start);
        end
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            want_bit   = idle_v[k % 10];
            want_start = ((k % 10) == 0);
            total++;
            if (txbit !== want_bit || sym_start !== want_start) begin
                bad++;
                $display("FAIL idle_bits k=%0d: got tx=%b start=%b, required tx=%b start=%b",
                         k, txbit, sym_start, want_bit, want_start);
            end
        end
        #1;
        total++;
        if (idle_seen - i0 !== 3) begin
            bad++;
            $display("FAIL idle_frames: got %0d, required 3", idle_seen - i0);
        end
        total++;
        if (underrun_cnt !== 8'd0) begin
            bad++;
            $display("FAIL idle_unarmed_cnt: got %0d, required 0", underrun_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] data [6];
        int         acc_cyc [6];
        int         idx, guard, d0, idle_a;
        logic       acc;
        data = '{10'h2AA, 10'h155, 10'h3FF, 10'h0F0, 10'h30C, 10'h1E1};
        idx = 0; guard = 0; d0 = data_seen; idle_a = -1;
        step();
        sym_valid = 1'b1;
        sym_in = data[0];
        while (idx < 6 && guard < 200) begin
            @(negedge clk);
            acc = sym_valid && sym_ready;
            if (acc) acc_cyc[idx] = cyc;
            step();
            guard++;
            if (acc) begin
                idx++;
                if (idx < 6) sym_in = data[idx];
                else sym_valid = 1'b0;
            end
        end
        sym_valid = 1'b0;
        total++;
        if (idx != 6) begin
            bad++;
            $display("FAIL b2b_accept_timeout: got %0d accepts, required 6", idx);
        end
        for (int i = 2; i < 6; i++) begin
            total++;
            if (acc_cyc[i] - acc_cyc[i-1] != 10) begin
                bad++;
                $display("FAIL b2b_accept_gap i=%0d: got %0d clk, required 10", i, acc_cyc[i] - acc_cyc[i-1]);
            end
        end
        guard = 0;
        while (data_seen < d0 + 6 && guard < 200) begin
            @(negedge clk);
            #1;
            if (data_seen >= d0 + 1 && idle_a < 0) idle_a = idle_seen;
            guard++;
        end
        total++;
        if (data_seen != d0 + 6) begin
            bad++;
            $display("FAIL b2b_frames: got %0d, required 6", data_seen - d0);
        end
        total++;
        if (idle_seen != idle_a) begin
            bad++;
            $display("FAIL b2b_gap_idle: got %0d idle frames, required 0", idle_seen - idle_a);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_leftover: got %0d queued, required 0", exp_q.size());
        end
    endtask

    task automatic test_underrun();
        int e0, i0, d0;
        step();
        reset = 1'b1; en_n = 1'b1; sym_valid = 1'b0;
        step();
        @(negedge clk);
        total++;
        if (underrun_cnt !== 8'd0 || sym_ready !== 1'b0 || txbit !== 1'b0) begin
            bad++;
            $display("FAIL ur_reset: got cnt=%0d rdy=%b tx=%b, required 0 0 0", underrun_cnt, sym_ready, txbit);
        end
        step();
        reset = 1'b0; en_n = 1'b0; sym_valid = 1'b1; sym_in = 10'h1C3;
        i0 = idle_seen; d0 = data_seen;
        step();
        e0 = cyc;
        sym_valid = 1'b0;
        wait_cyc(e0 + 5);
        total++;
        if (underrun_cnt !== 8'd0) begin
            bad++;
            $display("FAIL ur_armed_start: got %0d, required 0", underrun_cnt);
        end
        wait_cyc(e0 + 15);
        total++;
        if (underrun_cnt !== 8'd1) begin
            bad++;
            $display("FAIL ur_count1: got %0d, required 1", underrun_cnt);
        end
        wait_cyc(e0 + 29);
        step();
        sym_valid = 1'b1; sym_in = 10'h06D;
        step();
        sym_valid = 1'b0;
        wait_cyc(e0 + 45);
        total++;
        if (underrun_cnt !== 8'd3) begin
            bad++;
            $display("FAIL ur_count3: got %0d, required 3", underrun_cnt);
        end
        wait_cyc(e0 + 49);
        #1;
        total++;
        if (data_seen - d0 != 2 || idle_seen - i0 != 3) begin
            bad++;
            $display("FAIL ur_frames: got data=%0d idle=%0d, required data=2 idle=3", data_seen - d0, idle_seen - i0);
        end
        wait_cyc(e0 + 2555);
        total++;
        if (underrun_cnt !== 8'd254) begin
            bad++;
            $display("FAIL ur_count254: got %0d, required 254", underrun_cnt);
        end
        wait_cyc(e0 + 2565);
        total++;
        if (underrun_cnt !== 8'd255) begin
            bad++;
            $display("FAIL ur_count255: got %0d, required 255", underrun_cnt);
        end
        wait_cyc(e0 + 3015);
        total++;
        if (underrun_cnt !== 8'd255) begin
            bad++;
            $display("FAIL ur_saturate: got %0d, required 255", underrun_cnt);
        end
    endtask

    task automatic test_disable();
        int         l0, guard, d0;
        logic [9:0] idle_v;
        idle_v = IDLE;
        l0 = -1;
        for (guard = 0; guard < 20; guard++) begin
            @(negedge clk);
            if (sym_start) begin
                l0 = cyc;
                break;
            end
        end
        total++;
        if (l0 < 0) begin
            bad++;
            $display("FAIL dis_find_start: got no sym_start in 20 clk, required one");
            l0 = cyc;
        end
        wait_cyc(l0 + 8);
        step();
        sym_valid = 1'b1; sym_in = 10'h3F0;
        step();
        sym_in = 10'h0CC;
        step();
        sym_valid = 1'b0;
        @(negedge clk);
        total++;
        if (sym_ready !== 1'b0) begin
            bad++;
            $display("FAIL dis_hr_full_ready: got %b, required 0", sym_ready);
        end
        wait_cyc(l0 + 13);
        step();
        en_n = 1'b1;
        @(negedge clk);
        total++;
        if (txbit !== 1'b1 || sym_ready !== 1'b0) begin
            bad++;
            $display("FAIL dis_bit4: got tx=%b rdy=%b, required tx=1 rdy=0", txbit, sym_ready);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if ({txbit, sym_ready, sym_start} !== 3'b000 || underrun_cnt !== 8'd255) begin
                bad++;
                $display("FAIL dis_off k=%0d: got tx=%b rdy=%b start=%b cnt=%0d, required 0 0 0 255",
                         k, txbit, sym_ready, sym_start, underrun_cnt);
            end
        end
        exp_q.delete();
        step();
        en_n = 1'b0;
        d0 = data_seen;
        @(negedge clk);
        total++;
        if (sym_ready !== 1'b1) begin
            bad++;
            $display("FAIL dis_hr_flushed: got rdy=%b, required 1", sym_ready);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total++;
            if (txbit !== idle_v[k] || sym_start !== (k == 0)) begin
                bad++;
                $display("FAIL dis_reenable_idle k=%0d: got tx=%b start=%b, required tx=%b start=%b",
                         k, txbit, sym_start, idle_v[k], (k == 0));
            end
        end
        for (int k = 0; k < 20; k++) @(negedge clk);
        #1;
        total++;
        if (data_seen != d0) begin
            bad++;
            $display("FAIL dis_dropped_resent: got %0d data frames, required 0", data_seen - d0);
        end
    endtask

    task automatic test_msb_and_async_reset();
        logic [9:0] w;
        logic       want_bit;
        step();
        reset_m = 1'b0;
        step();
        en_n_m = 1'b0; sym_valid_m = 1'b1; sym_in_m = 10'h201;
        step();
        sym_valid_m = 1'b0;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            w = (k < 10) ? 10'h201 : IDLE;
            want_bit = w[9 - (k % 10)];
            total++;
            if (txbit_m !== want_bit || sym_start_m !== ((k % 10) == 0)) begin
                bad++;
                $display("FAIL msb_bits k=%0d: got tx=%b start=%b, required tx=%b start=%b",
                         k, txbit_m, sym_start_m, want_bit, ((k % 10) == 0));
            end
        end
        total++;
        if (underrun_cnt_m !== 8'd1) begin
            bad++;
            $display("FAIL msb_underrun: got %0d, required 1", underrun_cnt_m);
        end
        #1;
        reset_m = 1'b1;
        reset = 1'b1;
        #1;
        total++;
        if ({txbit_m, sym_start_m, sym_ready_m} !== 3'b000 || underrun_cnt_m !== 8'd0) begin
            bad++;
            $display("FAIL msb_async_reset: got tx=%b start=%b rdy=%b cnt=%0d, required 0 0 0 0",
                     txbit_m, sym_start_m, sym_ready_m, underrun_cnt_m);
        end
        total++;
        if ({txbit, sym_start, sym_ready} !== 3'b000 || underrun_cnt !== 8'd0) begin
            bad++;
            $display("FAIL lsb_async_reset: got tx=%b start=%b rdy=%b cnt=%0d, required 0 0 0 0",
                     txbit, sym_start, sym_ready, underrun_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_back_to_back();
        test_underrun();
        test_disable();
        test_msb_and_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
